ikbd_inputs: RTL and testbench
==============================

# ikbd_inputs

Parametrised input front-end for the Atari ST ikbd. It holds the key state of a ROWS×COLS keyboard matrix, updated from a make/break event stream, and answers the 6301's column scan. It converts relative mouse motion into rate-limited quadrature signals, and muxes mouse or joystick onto port-0 pins. It sits between the host input layer (USB/HID bridge) and the ikbd wrapper's `matrix_in` / `joystick0` inputs.

## Interface
Parameters:
- `ROWS`, 8: matrix rows (width of `matrix_in`).
- `COLS`, 15: matrix columns (width of `matrix_out`).
- `DW`, 8: width of signed mouse delta inputs.
- `ACC_W`, 10: width of signed per-axis motion accumulator; `ACC_W` > `DW`.
- `QDIV`, 64: clocks per quadrature step; `QDIV` ≥ 2.

Ports:
- `clk`  in  1  system clock (same 2 MHz domain as the ikbd).
- `res_n`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  key event offered.
- `key_ready`  out  1  key event accepted when `key_valid & key_ready`.
- `key_row`  in  $clog2(ROWS)  row index of event.
- `key_col`  in  $clog2(COLS)  column index of event.
- `key_press`  in  1  1 = make, 0 = break.
- `key_clear`  in  1  release all keys (host disconnect).
- `matrix_out`  in  COLS  column drive from the 6301, active-low.
- `matrix_in`  out  ROWS  row sense to the 6301, active-low.
- `mouse_valid`  in  1  motion report strobe, always accepted.
- `mouse_dx`, `mouse_dy`  in  DW  signed deltas, +x right, +y down.
- `mouse_btn`  in  2  {right, left}, 1 = pressed.
- `joy_mode`  in  1  0 = mouse on port 0, 1 = joystick on port 0.
- `joy0`  in  5  joystick {fire, R, L, D, U}, 1 = active.
- `port0`  out  6  to the ikbd `joystick0` input.

## Operation
- Key state: ROWS×COLS bit array, 1 = pressed.
- Key handshake:
  - `key_ready` = 0 in any cycle with `res_n`=0 or `key_clear`=1; otherwise 1.
  - On accept, bit [row][col] ← `key_press`, visible from the next cycle.
  - Out-of-range row or column: the event is accepted and discarded.
  - Repeated make or break of the same key is idempotent.
- `key_clear`: all bits ← 0 next cycle. Clear wins over a simultaneous event.
- Matrix sense, registered: `matrix_in[r]` ← ~|(state[r][*] & ~`matrix_out`). Multiple driven columns OR together (ghosting is intentionally reproduced).
- Mouse accumulation, per axis:
  - `acc` ← sat(acc + delta·`mouse_valid` − step), where step ∈ {−1, 0, +1}.
  - Saturation is to ±(2^(ACC_W−1)−1).
  - `mouse_btn` is latched on `mouse_valid`.
- Step timer:
  - Down-counter from QDIV−1; a tick is produced at 0, then it reloads.
  - On a tick, each axis with acc≠0 takes step = sign(acc).
  - Its 2-bit gray phase advances one position: 00→01→11→10→00 for a positive step, reverse for negative.
  - Phase bits are {b, a}.
- Axes are independent. Both may step on the same tick.
- Mode:
  - `joy_mode`=1: `port0` = {`joy0`[4], 0, `joy0`[3:0]}.
  - `joy_mode`=0: `port0` = {btn_r, btn_l, y_b, y_a, x_b, x_a}.
  - Any change of `joy_mode` zeroes both accumulators next cycle. Phases are held.
  - Accumulation continues while `joy_mode`=1.

## Timing
- Reset, applied synchronously (values hold while `res_n`=0):
  - key state 0, `matrix_in` all 1;
  - accumulators 0, phases 00, buttons 0;
  - timer QDIV−1;
  - `port0` 0 in mouse mode;
  - `key_ready` 0.
- A reset mid-stream discards the pending event and all motion.
- Key event accept to `matrix_in` change: 2 clocks, with matching column driven.
- `matrix_out` change to `matrix_in`: 1 clock.
- `port0` is registered:
  - phase change is visible 1 clock after the tick;
  - joystick pins are visible 1 clock after `joy0` changes.
- Maximum quadrature rate is one step per QDIV clocks per axis. A single report of +d produces |d| steps over |d|·QDIV clocks unless further reports arrive.

## Structure
- Package `ikbd_inputs_pkg`:
  - `port0` bit-index constants;
  - gray-step function (phase, dir) → phase;
  - signed saturating-add function parametrised by width.
- Sub-module `ikbd_quad_axis`, instantiated for x and y. It contains:
  - the accumulator;
  - the gray phase;
  - inputs `tick`, `delta`, `load`, `zero`, and output `{b, a}`.
- Key array and matrix sense live in the top.

## Test plan
- Reset: hold `res_n`=0 for 3 clocks with `key_valid`=1 → `matrix_in`=8'hFF, `port0`=0, `key_ready`=0, no state change after release.
- Keys:
  - press row 3 col 5; drive `matrix_out`=~(1<<5) → `matrix_in`=8'hF7 two clocks after accept;
  - drive `matrix_out`=~(1<<6) → 8'hFF;
  - break → 8'hFF;
  - out-of-range col 15 → no change.
- Clear race: `key_clear`=1 together with a make of row 0 col 0 → key not pressed, `key_ready`=0 that cycle.
- Mouse:
  - `mouse_dx`=+3, QDIV=4 → x phase 00→01→11→10 at ticks 4 clocks apart, then idle;
  - `mouse_dy`=−2 → y phase 00→10→11.
- Saturation and mode:
  - five reports of dx=+127 with ACC_W=10 → acc saturates at +511;
  - toggling `joy_mode` → acc 0, stepping stops;
  - `joy0`=5'b10001 → `port0`=6'b100001.

Source files
------------

// File: rtl/ikbd_inputs_pkg.sv
// rtl/ikbd_inputs_pkg.sv - port0 bit map, gray quadrature stepping and saturating add
package ikbd_inputs_pkg;

   localparam int P0_X_A   = 0;
   localparam int P0_X_B   = 1;
   localparam int P0_Y_A   = 2;
   localparam int P0_Y_B   = 3;
   localparam int P0_BTN_L = 4;
   localparam int P0_BTN_R = 5;
   localparam int P0_FIRE  = 5;

   // Phase is {b, a}; forward order is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] gray_step(input logic [1:0] ph, input logic neg);
      logic [1:0] nxt;
      case (ph)
         2'b00:   nxt = neg ? 2'b10 : 2'b01;
         2'b01:   nxt = neg ? 2'b00 : 2'b11;
         2'b11:   nxt = neg ? 2'b01 : 2'b10;
         default: nxt = neg ? 2'b11 : 2'b00;
      endcase
      return nxt;
   endfunction

   // Symmetric saturation to +/-(2^(w-1)-1).
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] sum;
      logic signed [32:0] lim;
      sum = 33'(a) + 33'(b);
      lim = (33'sd1 <<< (w - 1)) - 33'sd1;
      if (sum > lim)
         sum = lim;
      else if (sum < -lim)
         sum = -lim;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/ikbd_quad_axis.sv
// rtl/ikbd_quad_axis.sv - one mouse axis: motion accumulator draining into a gray quadrature phase
module ikbd_quad_axis
   import ikbd_inputs_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ACC_W = 10
)
(
   input  logic          clk,
   input  logic          res_n,
   input  logic          tick,
   input  logic          load,
   input  logic          zero,
   input  logic [DW-1:0] delta,
   output logic [1:0]    phase
);

   logic signed [ACC_W-1:0] acc;
   logic signed [31:0]      adj;
   logic                    take;

   always_comb begin
      take = tick && (acc != '0);
      adj  = load ? 32'($signed(delta)) : 32'sd0;
      if (take)
         adj = acc[ACC_W-1] ? adj + 32'sd1 : adj - 32'sd1;
   end

   // Clearing on a mode change leaves the phase where it is so the pins do not glitch.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         acc   <= '0;
         phase <= 2'b00;
      end else if (zero) begin
         acc   <= '0;
      end else begin
         acc <= ACC_W'(sat_add(32'(acc), adj, ACC_W));
         if (take)
            phase <= gray_step(phase, acc[ACC_W-1]);
      end
   end

endmodule

// File: rtl/ikbd_inputs.sv
// rtl/ikbd_inputs.sv - key matrix, quadrature mouse and joystick front-end for the ikbd
module ikbd_inputs
   import ikbd_inputs_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int COLS  = 15,
   parameter int DW    = 8,
   parameter int ACC_W = 10,
   parameter int QDIV  = 64
)
(
   input  logic                     clk,
   input  logic                     res_n,
   input  logic                     key_valid,
   output logic                     key_ready,
   input  logic [$clog2(ROWS)-1:0]  key_row,
   input  logic [$clog2(COLS)-1:0]  key_col,
   input  logic                     key_press,
   input  logic                     key_clear,
   input  logic [COLS-1:0]          matrix_out,
   output logic [ROWS-1:0]          matrix_in,
   input  logic                     mouse_valid,
   input  logic [DW-1:0]            mouse_dx,
   input  logic [DW-1:0]            mouse_dy,
   input  logic [1:0]               mouse_btn,
   input  logic                     joy_mode,
   input  logic [4:0]               joy0,
   output logic [5:0]               port0
);

   localparam int TW = $clog2(QDIV);

   logic [ROWS-1:0][COLS-1:0] key_state;
   logic [TW-1:0]             timer;
   logic                      tick;
   logic                      key_hit;
   logic                      mode_q;
   logic                      mode_chg;
   logic [1:0]                btn;
   logic [1:0]                x_ph;
   logic [1:0]                y_ph;
   logic [5:0]                port0_next;

   assign key_ready = res_n && !key_clear;
   assign key_hit   = key_valid && key_ready &&
                      (32'(key_row) < ROWS) && (32'(key_col) < COLS);
   assign tick      = (timer == '0);
   assign mode_chg  = (joy_mode != mode_q);

   always_ff @(posedge clk) begin
      if (!res_n || key_clear)
         key_state <= '0;
      else if (key_hit)
         key_state[key_row][key_col] <= key_press;
   end

   // Several driven columns OR together, so ghost keys appear as on the real matrix.
   always_ff @(posedge clk) begin
      if (!res_n)
         matrix_in <= '1;
      else
         for (int r = 0; r < ROWS; r++)
            matrix_in[r] <= ~|(key_state[r] & ~matrix_out);
   end

   ikbd_quad_axis #(.DW(DW), .ACC_W(ACC_W)) u_quad_x (
      .clk   (clk),
      .res_n (res_n),
      .tick  (tick),
      .load  (mouse_valid),
      .zero  (mode_chg),
      .delta (mouse_dx),
      .phase (x_ph)
   );

   ikbd_quad_axis #(.DW(DW), .ACC_W(ACC_W)) u_quad_y (
      .clk   (clk),
      .res_n (res_n),
      .tick  (tick),
      .load  (mouse_valid),
      .zero  (mode_chg),
      .delta (mouse_dy),
      .phase (y_ph)
   );

   always_comb begin
      port0_next = '0;
      if (joy_mode) begin
         port0_next[P0_FIRE] = joy0[4];
         port0_next[3:0]     = joy0[3:0];
      end else begin
         port0_next[P0_X_A]   = x_ph[0];
         port0_next[P0_X_B]   = x_ph[1];
         port0_next[P0_Y_A]   = y_ph[0];
         port0_next[P0_Y_B]   = y_ph[1];
         port0_next[P0_BTN_L] = btn[0];
         port0_next[P0_BTN_R] = btn[1];
      end
   end

   // mode_q follows joy_mode through reset so leaving reset is not seen as a mode change.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         mode_q <= joy_mode;
         btn    <= 2'b00;
         timer  <= TW'(QDIV - 1);
         port0  <= '0;
      end else begin
         mode_q <= joy_mode;
         if (mouse_valid)
            btn <= mouse_btn;
         timer <= tick ? TW'(QDIV - 1) : timer - TW'(1);
         port0 <= port0_next;
      end
   end

endmodule

// File: tb/tb_ikbd_inputs.sv
// tb/tb_ikbd_inputs.sv - directed self-checking bench for ikbd_inputs
module tb_ikbd_inputs;

   logic        clk = 1'b0;
   logic        res_n;
   logic        key_valid;
   logic        key_ready;
   logic [2:0]  key_row;
   logic [3:0]  key_col;
   logic        key_press;
   logic        key_clear;
   logic [14:0] matrix_out;
   logic [7:0]  matrix_in;
   logic        mouse_valid;
   logic [7:0]  mouse_dx;
   logic [7:0]  mouse_dy;
   logic [1:0]  mouse_btn;
   logic        joy_mode;
   logic [4:0]  joy0;
   logic [5:0]  port0;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   ikbd_inputs #(.ROWS(8), .COLS(15), .DW(8), .ACC_W(10), .QDIV(4)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_row     (key_row),
      .key_col     (key_col),
      .key_press   (key_press),
      .key_clear   (key_clear),
      .matrix_out  (matrix_out),
      .matrix_in   (matrix_in),
      .mouse_valid (mouse_valid),
      .mouse_dx    (mouse_dx),
      .mouse_dy    (mouse_dy),
      .mouse_btn   (mouse_btn),
      .joy_mode    (joy_mode),
      .joy0        (joy0),
      .port0       (port0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ph(input int lsb, output int cnt);
      logic [1:0] prev;
      prev = port0[lsb +: 2];
      cnt  = 0;
      while (port0[lsb +: 2] == prev && cnt < 20) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      res_n = 1'b0; key_valid = 1'b1; key_row = 3'd3; key_col = 4'd5; key_press = 1'b1;
      key_clear = 1'b0; matrix_out = 15'h0000; mouse_valid = 1'b1; mouse_dx = 8'd5;
      mouse_dy = 8'd0; mouse_btn = 2'b11; joy_mode = 1'b0; joy0 = 5'b0;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", 32'(key_ready), 32'd0);
         chk("rst_matrix", 32'(matrix_in), 32'hFF);
         chk("rst_port0", 32'(port0), 32'd0);
      end
      res_n = 1'b1; key_valid = 1'b0; mouse_valid = 1'b0; mouse_btn = 2'b01;
      step(); step();
      chk("rel_matrix", 32'(matrix_in), 32'hFF);
      chk("rel_port0", 32'(port0), 32'd0);
      chk("rel_acc", 32'(dut.u_quad_x.acc), 32'd0);

      // Key press, column selection, break
      key_valid = 1'b1; key_row = 3'd3; key_col = 4'd5; key_press = 1'b1;
      matrix_out = ~(15'd1 << 5);
      #1 chk("key_ready", 32'(key_ready), 32'd1);
      step(); key_valid = 1'b0;
      chk("key_lat1", 32'(matrix_in), 32'hFF);
      step();
      chk("key_lat2", 32'(matrix_in), 32'hF7);
      matrix_out = ~(15'd1 << 6);
      step();
      chk("key_othercol", 32'(matrix_in), 32'hFF);
      matrix_out = ~(15'd1 << 5);
      step();
      chk("key_col_back", 32'(matrix_in), 32'hF7);
      key_valid = 1'b1; key_press = 1'b0;
      step(); key_valid = 1'b0;
      step();
      chk("key_break", 32'(matrix_in), 32'hFF);

      key_valid = 1'b1; key_col = 4'd15; key_press = 1'b1; matrix_out = 15'h0000;
      step(); key_valid = 1'b0;
      step();
      chk("key_oor", 32'(matrix_in), 32'hFF);

      // Two keys on different rows/cols with every column driven
      key_valid = 1'b1; key_row = 3'd3; key_col = 4'd5;
      step(); key_row = 3'd1; key_col = 4'd2;
      step(); key_valid = 1'b0;
      step();
      chk("key_multi", 32'(matrix_in), 32'hF5);

      // Clear beats a simultaneous make
      key_clear = 1'b1; key_valid = 1'b1; key_row = 3'd0; key_col = 4'd0;
      #1 chk("clr_ready", 32'(key_ready), 32'd0);
      step(); key_clear = 1'b0; key_valid = 1'b0;
      step();
      chk("clr_matrix", 32'(matrix_in), 32'hFF);

      // Mouse x +3
      mouse_valid = 1'b1; mouse_dx = 8'd3; mouse_dy = 8'd0;
      step(); mouse_valid = 1'b0;
      step();
      chk("btn_latch", 32'(port0[5:4]), 32'd1);
      wait_ph(0, n);
      chk("x_ph1", 32'(port0[1:0]), 32'b01);
      wait_ph(0, n);
      chk("x_ph2", 32'(port0[1:0]), 32'b11);
      chk("x_gap2", 32'(n), 32'd4);
      wait_ph(0, n);
      chk("x_ph3", 32'(port0[1:0]), 32'b10);
      chk("x_gap3", 32'(n), 32'd4);
      wait_ph(0, n);
      chk("x_idle", 32'(n), 32'd20);

      // Mouse y -2
      mouse_valid = 1'b1; mouse_dx = 8'd0; mouse_dy = 8'hFE;
      step(); mouse_valid = 1'b0;
      wait_ph(2, n);
      chk("y_ph1", 32'(port0[3:2]), 32'b10);
      wait_ph(2, n);
      chk("y_ph2", 32'(port0[3:2]), 32'b11);
      chk("y_gap2", 32'(n), 32'd4);
      wait_ph(2, n);
      chk("y_idle", 32'(n), 32'd20);
      chk("x_held", 32'(port0[1:0]), 32'b10);

      // Saturation
      mouse_valid = 1'b1; mouse_dx = 8'd127; mouse_dy = 8'd0;
      for (int i = 0; i < 5; i++) step();
      mouse_valid = 1'b0;
      chk("sat_acc", 32'(dut.u_quad_x.acc), 32'd511);

      // Mode switching
      joy_mode = 1'b1; joy0 = 5'b10001;
      step();
      chk("mode_acc0", 32'(dut.u_quad_x.acc), 32'd0);
      chk("joy_port0a", 32'(port0), 32'b100001);
      joy0 = 5'b01010;
      step();
      chk("joy_port0b", 32'(port0), 32'b001010);
      joy_mode = 1'b0;
      step();
      chk("mode_back_acc", 32'(dut.u_quad_x.acc), 32'd0);
      chk("mode_back_btn", 32'(port0[5:4]), 32'd1);
      wait_ph(0, n);
      chk("mode_stopped", 32'(n), 32'd20);

      // Reset mid-stream discards motion
      mouse_valid = 1'b1; mouse_dx = 8'd5;
      step(); mouse_valid = 1'b0; res_n = 1'b0;
      step(); res_n = 1'b1;
      step();
      chk("midrst_port0", 32'(port0), 32'd0);
      chk("midrst_acc", 32'(dut.u_quad_x.acc), 32'd0);
      wait_ph(0, n);
      chk("midrst_idle", 32'(n), 32'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
